// File: rtl/sysid_pkg.sv
// Shared word map, CAPS bit positions and uptime width for the sysid slave.
package sysid_pkg;

   localparam int unsigned ID_WORD      = 0;
   localparam int unsigned TS_WORD      = 1;
   localparam int unsigned UP_LO_WORD   = 2;
   localparam int unsigned UP_HI_WORD   = 3;
   localparam int unsigned SCRATCH_WORD = 4;
   localparam int unsigned CAPS_WORD    = 5;
   localparam int unsigned INFO_BASE    = 6;

   localparam int unsigned CAPS_NUM_INFO_LSB = 0;
   localparam int unsigned CAPS_UPTIME_BIT   = 8;

   localparam int unsigned UPTIME_W = 64;

endpackage

// File: rtl/sysid_uptime_ctr.sv
// Free-running 64-bit uptime counter with synchronous clear and a hi-half
// snapshot captured whenever the lo half is read.
module sysid_uptime_ctr
   import sysid_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        clear,
   input  logic        snap,
   output logic [31:0] count_lo,
   output logic [31:0] hi_snap
);

   logic [UPTIME_W-1:0] count_reg;
   logic [31:0]         hi_snap_reg;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_reg   <= '0;
         hi_snap_reg <= '0;
      end else if (clear) begin
         count_reg   <= '0;
         hi_snap_reg <= '0;
      end else begin
         count_reg <= count_reg + 1'b1;
         // Hi half captured from the same pre-edge value the lo read returns.
         if (snap)
            hi_snap_reg <= count_reg[UPTIME_W-1:32];
      end
   end

   assign count_lo = count_reg[31:0];
   assign hi_snap  = hi_snap_reg;

endmodule

// File: rtl/sysid_info_regs.sv
// System-identification Avalon-MM slave: ID, timestamp, caps, info words,
// scratch and optional uptime counter (enabled by defining SYSID_UPTIME_EN).
module sysid_info_regs
   import sysid_pkg::*;
#(
   parameter logic [31:0]            ID_VALUE   = 32'h0,
   parameter logic [31:0]            TIMESTAMP  = 32'h0,
   parameter int                     NUM_INFO   = 4,
   parameter logic [NUM_INFO*32-1:0] INFO_WORDS = '0,
   parameter int                     ADDR_W     = 5
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] address,
   input  logic              read,
   input  logic              write,
   input  logic [31:0]       writedata,
   input  logic [3:0]        byteenable,
   output logic [31:0]       readdata,
   output logic              readdatavalid
);

   logic        read_accept;
   logic        scratch_we;
   logic [31:0] scratch_reg;
   logic [31:0] scratch_next;
   logic [31:0] read_word;
   logic [31:0] caps_word;
   logic [31:0] uptime_lo;
   logic [31:0] uptime_hi;
   logic        uptime_present;
   logic [31:0] readdata_reg;
   logic        readdatavalid_reg;

   // A simultaneous write wins; the read is dropped entirely.
   assign read_accept = read && !write;
   assign scratch_we  = write && (address == ADDR_W'(SCRATCH_WORD));

`ifdef SYSID_UPTIME_EN
   assign uptime_present = 1'b1;

   sysid_uptime_ctr u_uptime (
      .clock    (clock),
      .reset    (reset),
      .clear    (write && (address == ADDR_W'(UP_LO_WORD))),
      .snap     (read_accept && (address == ADDR_W'(UP_LO_WORD))),
      .count_lo (uptime_lo),
      .hi_snap  (uptime_hi)
   );
`else
   assign uptime_present = 1'b0;
   assign uptime_lo      = '0;
   assign uptime_hi      = '0;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_scratch_lane
         assign scratch_next[gi*8 +: 8] = (scratch_we && byteenable[gi])
                                          ? writedata[gi*8 +: 8]
                                          : scratch_reg[gi*8 +: 8];
      end
   endgenerate

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         scratch_reg <= '0;
      else
         scratch_reg <= scratch_next;
   end

   always_comb begin
      caps_word = '0;
      caps_word[CAPS_NUM_INFO_LSB +: 8] = 8'(NUM_INFO);
      caps_word[CAPS_UPTIME_BIT]        = uptime_present;
   end

   always_comb begin
      read_word = '0;
      case (address)
         ADDR_W'(ID_WORD):      read_word = ID_VALUE;
         ADDR_W'(TS_WORD):      read_word = TIMESTAMP;
         ADDR_W'(UP_LO_WORD):   read_word = uptime_lo;
         ADDR_W'(UP_HI_WORD):   read_word = uptime_hi;
         ADDR_W'(SCRATCH_WORD): read_word = scratch_reg;
         ADDR_W'(CAPS_WORD):    read_word = caps_word;
         default:               read_word = '0;
      endcase
      for (int k = 0; k < NUM_INFO; k++) begin
         if (address == ADDR_W'(INFO_BASE + k))
            read_word = INFO_WORDS[32*k +: 32];
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         readdata_reg      <= '0;
         readdatavalid_reg <= 1'b0;
      end else begin
         readdatavalid_reg <= read_accept;
         if (read_accept)
            readdata_reg <= read_word;
      end
   end

   assign readdata      = readdata_reg;
   assign readdatavalid = readdatavalid_reg;

endmodule
